// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scanner: one GAP/DRIVE slot per digit and tear-free frame commit at the 3->0 wrap.
// Optional macro HEX_DECODE_EN decodes codes 10..15 as A,b,C,d,E,F instead of blanking them.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 16,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] frame_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    pending,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam logic [0:0] S_GAP   = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_frame_q, act_frame_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [4*NUM_DIGITS-1:0] pend_frame_q, pend_frame_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pending_q, pending_d;
  logic                    load_ack_q, load_ack_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

  logic       wrap;
  logic       boundary;
  logic [3:0] cur_digit;
  logic       cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
`ifdef HEX_DECODE_EN
      4'd10:   s = 7'b0001000;
      4'd11:   s = 7'b0000011;
      4'd12:   s = 7'b1000110;
      4'd13:   s = 7'b0100001;
      4'd14:   s = 7'b0000110;
      4'd15:   s = 7'b0001110;
`endif
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    act_frame_d  = act_frame_q;
    act_blank_d  = act_blank_q;
    pend_frame_d = pend_frame_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;

    wrap     = enable && (cnt_q == CNT_LAST);
    boundary = wrap && (idx_q == IDX_LAST);

    if (enable) begin
      if (wrap) begin
        cnt_d   = '0;
        state_d = S_GAP;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == S_GAP && cnt_q == GAP_LAST) state_d = S_DRIVE;
      end
    end

    // Commit takes the pre-load pending contents; a same-cycle load then refills pending.
    if (boundary && pending_q) begin
      act_frame_d = pend_frame_q;
      act_blank_d = pend_blank_q;
      pending_d   = 1'b0;
      load_ack_d  = 1'b1;
    end
    if (load) begin
      pend_frame_d = frame_in;
      pend_blank_d = blank_in;
      pending_d    = 1'b1;
    end
  end

  // Segments and anodes come from the same pre-edge state, so they always switch together.
  always_comb begin
    cur_digit = act_frame_q[idx_q*4 +: 4];
    cur_blank = act_blank_q[idx_q];
    seg_n_d   = 7'b1111111;
    an_n_d    = '1;
    if (enable && state_q == S_DRIVE) begin
      an_n_d  = ~(AN_ONE << idx_q);
      seg_n_d = cur_blank ? 7'b1111111 : seg_decode(cur_digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GAP;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_frame_q  <= '0;
      act_blank_q  <= '1;
      pend_frame_q <= '0;
      pend_blank_q <= '1;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      seg_n_q      <= 7'b1111111;
      an_n_q       <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_frame_q  <= act_frame_d;
      act_blank_q  <= act_blank_d;
      pend_frame_q <= pend_frame_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
    end
  end

  assign load_ack  = load_ack_q;
  assign pending   = pending_q;
  assign seg_n     = seg_n_q;
  assign an_n      = an_n_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 4 digits, 8-clock slots and a 2-clock gap.
// Edge numbers count rising edges since reset release; each slot k of a frame starting at edge B drives from B+8k+3.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] frame_in;
  logic [3:0]  blank_in;
  logic        load;
  logic        load_ack;
  logic        pending;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;

  int checks;
  int failures;
  int edge_n;
  int ack_total;
  int ack_mark;

  display_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIGIT_CYCLES(8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .frame_in (frame_in),
    .blank_in (blank_in),
    .load     (load),
    .load_ack (load_ack),
    .pending  (pending),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .digit_idx(digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (load_ack === 1'b1) ack_total++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  // Drive load so that it is sampled on edge e.
  task automatic do_load(input logic [15:0] f, input logic [3:0] b, input int e);
    run_to(e - 1);
    frame_in = f;
    blank_in = b;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    logic [6:0] exp_hex_b;
`ifdef HEX_DECODE_EN
    exp_hex_b = 7'b0000011;
`else
    exp_hex_b = 7'b1111111;
`endif
    checks    = 0;
    failures  = 0;
    edge_n    = 0;
    ack_total = 0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    frame_in  = '0;
    blank_in  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 16'(seg_n), 16'h7f);
    chk("rst_an", 16'(an_n), 16'hf);
    chk("rst_idx", 16'(digit_idx), 16'h0);
    chk("rst_ack", 16'(load_ack), 16'h0);
    chk("rst_pend", 16'(pending), 16'h0);

    rst_n  = 1'b1;
    enable = 1'b1;

    // Slot sequencing with an empty (all-blank) frame
    run_to(1);  chk("gap0_an_e1", 16'(an_n), 16'hf);
    run_to(2);  chk("gap0_an_e2", 16'(an_n), 16'hf);
    run_to(3);  chk("drv0_an", 16'(an_n), 16'he);
                chk("drv0_seg_blank", 16'(seg_n), 16'h7f);
    run_to(8);  chk("drv0_an_last", 16'(an_n), 16'he);
                chk("idx_after_wrap", 16'(digit_idx), 16'h1);
    run_to(9);  chk("gap1_an", 16'(an_n), 16'hf);
    run_to(11); chk("drv1_an", 16'(an_n), 16'hd);
    run_to(31); chk("idx_before_bnd", 16'(digit_idx), 16'h3);
    run_to(32); chk("idx_bnd", 16'(digit_idx), 16'h0);

    // Single load mid-frame commits at the next 3->0 wrap
    do_load(16'h4321, 4'b0000, 41);
    chk("pend_after_load", 16'(pending), 16'h1);
    run_to(63); chk("pend_hold", 16'(pending), 16'h1);
                chk("ack_before_bnd", 16'(load_ack), 16'h0);
    run_to(64); chk("ack_bnd", 16'(load_ack), 16'h1);
                chk("pend_clr", 16'(pending), 16'h0);
    run_to(65); chk("ack_one_cycle", 16'(load_ack), 16'h0);
    run_to(67); chk("d0_an", 16'(an_n), 16'he);
                chk("d0_seg_1", 16'(seg_n), 16'h79);
    run_to(91); chk("d3_an", 16'(an_n), 16'h7);
                chk("d3_seg_4", 16'(seg_n), 16'h19);

    // Two loads before a boundary: last wins, one ack
    do_load(16'h1111, 4'b0000, 92);
    ack_mark = ack_total;
    do_load(16'h9999, 4'b0000, 93);
    run_to(95);  chk("dbl_pend", 16'(pending), 16'h1);
    run_to(99);  chk("dbl_d0_seg_9", 16'(seg_n), 16'h10);
    run_to(115); chk("dbl_d2_an", 16'(an_n), 16'hb);
                 chk("dbl_d2_seg_9", 16'(seg_n), 16'h10);
    run_to(119); chk("dbl_ack_count", 16'(ack_total - ack_mark), 16'h1);

    // Load on the commit edge: first frame commits, second waits one frame
    do_load(16'h5555, 4'b0000, 120);
    do_load(16'h7777, 4'b0000, 128);
    chk("coll_ack1", 16'(load_ack), 16'h1);
    chk("coll_pend", 16'(pending), 16'h1);
    run_to(131); chk("coll_d0_seg_5", 16'(seg_n), 16'h12);
    run_to(159); chk("coll_no_early_ack", 16'(load_ack), 16'h0);
    run_to(160); chk("coll_ack2", 16'(load_ack), 16'h1);
                 chk("coll_pend_clr", 16'(pending), 16'h0);
    run_to(163); chk("coll_d0_seg_7", 16'(seg_n), 16'h78);

    // Hex code and per-digit blank
    do_load(16'h85B0, 4'b0100, 170);
    run_to(195); chk("hx_d0_seg_0", 16'(seg_n), 16'h40);
    run_to(203); chk("hx_d1_an", 16'(an_n), 16'hd);
                 chk("hx_d1_seg_b", 16'(seg_n), 16'(exp_hex_b));
    run_to(211); chk("hx_d2_an", 16'(an_n), 16'hb);
                 chk("hx_d2_seg_blank", 16'(seg_n), 16'h7f);
    run_to(219); chk("hx_d3_seg_8", 16'(seg_n), 16'h00);

    // enable low for 20 clocks mid-DRIVE of digit 0; capture still works
    run_to(230);
    enable = 1'b0;
    run_to(231); chk("dis_an", 16'(an_n), 16'hf);
                 chk("dis_seg", 16'(seg_n), 16'h7f);
    do_load(16'h2222, 4'b0000, 235);
    chk("dis_pend", 16'(pending), 16'h1);
    run_to(250); chk("dis_an_hold", 16'(an_n), 16'hf);
                 chk("dis_idx_hold", 16'(digit_idx), 16'h0);
    enable = 1'b1;
    run_to(251); chk("en_an", 16'(an_n), 16'he);
                 chk("en_seg_0", 16'(seg_n), 16'h40);
                 chk("en_idx", 16'(digit_idx), 16'h0);
    run_to(252); chk("en_idx_wrap", 16'(digit_idx), 16'h1);
    run_to(275); chk("en_no_early_ack", 16'(load_ack), 16'h0);
    run_to(276); chk("en_ack", 16'(load_ack), 16'h1);
    run_to(279); chk("en_d0_seg_2", 16'(seg_n), 16'h24);

    // Async reset mid-DRIVE drops a pending frame
    do_load(16'h6666, 4'b0000, 280);
    chk("rs_pend_before", 16'(pending), 16'h1);
    run_to(281);
    rst_n = 1'b0;
    #2;
    chk("rs_an", 16'(an_n), 16'hf);
    chk("rs_seg", 16'(seg_n), 16'h7f);
    chk("rs_pend", 16'(pending), 16'h0);
    chk("rs_idx", 16'(digit_idx), 16'h0);
    tick();
    tick();
    rst_n    = 1'b1;
    edge_n   = 0;
    ack_mark = ack_total;
    run_to(3);  chk("rs_d0_an", 16'(an_n), 16'he);
                chk("rs_d0_seg_blank", 16'(seg_n), 16'h7f);
    run_to(40); chk("rs_no_ack", 16'(ack_total - ack_mark), 16'h0);
                chk("rs_pend_after", 16'(pending), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment bus with active-low digit enables. The host loads a new frame through a pending register and a load/ack handshake. The frame reaches the display only at a frame boundary, so no digit tears. Each digit slot has a dead-time gap to suppress ghosting. The block sits between counter/ALU logic and the board's multiplexed display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
DIGIT_CYCLES, 50000, clocks per digit slot including gap (>= GAP_CYCLES+2)
GAP_CYCLES, 16, clocks at start of each slot with all anodes off (>= 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan runs; 0 = outputs forced blank, scan position held
frame_in  in  4*NUM_DIGITS  BCD digits, digit 0 in bits [3:0]
blank_in  in  NUM_DIGITS  per-digit blank mask, captured with frame_in
load  in  1  one-cycle strobe, capture frame_in/blank_in into pending
load_ack  out  1  one-cycle pulse when the pending frame commits to display
pending  out  1  1 while a loaded frame awaits commit
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
an_n  out  NUM_DIGITS  digit enables, active-low, at most one low
digit_idx  out  clog2(NUM_DIGITS)  digit currently in slot

Behaviour:
- Reset (async assert, sync release): seg_n=7'b1111111, an_n=all 1, digit_idx=0, load_ack=0, pending=0, slot counter=0, state=GAP. Active and pending frame registers clear to 0; blank masks clear to all 1.
- States: GAP, DRIVE.
  - GAP: an_n all 1, seg_n all 1. Lasts GAP_CYCLES clocks, then DRIVE.
  - DRIVE: an_n[digit_idx]=0, seg_n=decode(active digit). Lasts DIGIT_CYCLES-GAP_CYCLES clocks.
- Slot counter counts 0..DIGIT_CYCLES-1 and wraps. On wrap: digit_idx increments modulo NUM_DIGITS, state returns to GAP.
- Frame boundary: the wrap where digit_idx goes NUM_DIGITS-1 -> 0. If pending=1 there, in that same cycle active <= pending registers, pending <= 0, and load_ack pulses high for exactly 1 cycle. Digit 0 of the new slot uses the new frame.
- load with pending=0: capture, pending=1 next cycle.
- load with pending=1: overwrite the pending registers; the last load wins; no ack for the discarded frame.
- load in the same cycle as a commit: commit uses the pre-load pending contents. The new load captures and pending stays 1; it commits at the next frame boundary.
- Decode: 0..9 map to 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Codes 10..15 map to 1111111. A digit whose blank bit is 1 gives 1111111, but its anode still sequences.
- seg_n and an_n are registered outputs, one clock behind the state/counter. Both change in the same cycle, so there is never a skew cycle where an anode is on with the previous digit's segments.
- enable=0: counter, state and digit_idx freeze; outputs go all 1 on the next clock; load/commit logic is unaffected only for capture, since commits need a frame boundary. enable 0->1 resumes from the frozen counter value.
- Async reset mid-frame: immediate return to reset values; a pending frame is lost.

Optional Feature:
HEX_DECODE_EN. Defined: codes 10..15 decode to A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Undefined: codes 10..15 blank (1111111). No port or timing change.

Test Plan:
- Reset then run with NUM_DIGITS=4, DIGIT_CYCLES=8, GAP_CYCLES=2: an_n goes 1111 for 2 clocks, then 1110 for 6 clocks, then 1111 for 2 and 1101 for 6; digit_idx wraps 3->0 every 32 clocks.
- load frame_in=16'h4321 mid-frame: pending=1 until the 3->0 wrap; load_ack pulses 1 cycle there; digit 0 shows 1111001, digit 3 shows 0011001.
- Two loads (16'h1111, then 16'h9999) before a boundary: exactly one load_ack; all digits show 0010000.
- load asserted on the commit cycle: first frame commits with ack, pending stays 1, and the second frame commits one frame (32 clocks) later with a second ack.
- frame_in nibble 4'hB, blank_in=4'b0100: without the macro digit 1 shows 1111111; with HEX_DECODE_EN it shows 0000011. Digit 2 is always 1111111 while an_n still reaches 1011.
- enable=0 for 20 clocks mid-DRIVE, and separately rst_n pulsed low mid-DRIVE: outputs all 1; with enable, digit_idx and counter resume unchanged; with reset, pending clears and no ack follows.
